// File: rtl/fifo_serial_tx_if.sv
// fifo_serial_tx_if -- bundle between the serial transmitter and its FIFO/controller side.
//   ienable : permit starting a new frame (sampled only while the transmitter is idle)
//   iempty  : FIFO empty flag
//   ir_data : FIFO show-ahead read data, valid whenever iempty is low
//   ord     : FIFO pop strobe, one cycle per word
//   otx     : serial line, idle high
//   obusy   : transmitter is mid-frame
//   odone   : one-cycle pulse in the last stop-bit cycle
// master = transmitter side, slave = FIFO/controller side.
interface fifo_serial_tx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              ienable;
    logic              iempty;
    logic [DATA_W-1:0] ir_data;
    logic              ord;
    logic              otx;
    logic              obusy;
    logic              odone;

    modport master (
        input  ienable,
        input  iempty,
        input  ir_data,
        output ord,
        output otx,
        output obusy,
        output odone
    );

    modport slave (
        output ienable,
        output iempty,
        output ir_data,
        input  ord,
        input  otx,
        input  obusy,
        input  odone
    );
endinterface

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx -- pops one word from a show-ahead FIFO and sends it as a serial frame:
// one low start bit, DATA_W data bits LSB first, one high stop bit, each bit CLKS_PER_BIT
// clocks long.
//   iclk   : clock, rising edge
//   ireset : asynchronous active-high reset; aborts any frame in flight
//   bus    : fifo_serial_tx_if.master (ienable, iempty, ir_data in; ord, otx, obusy, odone out)
module fifo_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              iclk,
    input  logic              ireset,
    fifo_serial_tx_if.master  bus
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudPenult = BaudW'(CLKS_PER_BIT - 2);
    localparam logic [BitW-1:0]  BitLast    = BitW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } stateT;

    stateT             state;
    logic [BaudW-1:0]  baudCnt;
    logic [BitW-1:0]   bitCnt;
    logic [DATA_W-1:0] shiftReg;
    logic              otxReg;
    logic              busyReg;
    logic              doneReg;
    logic              popNow;

    // Pop is combinational so the show-ahead word is captured on the same edge that
    // advances the FIFO; gating with ireset keeps the FIFO untouched during reset.
    assign popNow    = (state == StIdle) & bus.ienable & ~bus.iempty & ~ireset;
    assign bus.ord   = popNow;
    assign bus.otx   = otxReg;
    assign bus.obusy = busyReg;
    assign bus.odone = doneReg;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state    <= StIdle;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            otxReg   <= 1'b1;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (popNow) begin
                        state    <= StStart;
                        shiftReg <= bus.ir_data;
                        baudCnt  <= '0;
                        otxReg   <= 1'b0;
                        busyReg  <= 1'b1;
                    end
                end

                StStart: begin
                    if (baudCnt == BaudLast) begin
                        baudCnt  <= '0;
                        bitCnt   <= '0;
                        state    <= StData;
                        otxReg   <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                    end else begin
                        baudCnt <= baudCnt + BaudW'(1);
                    end
                end

                StData: begin
                    if (baudCnt == BaudLast) begin
                        baudCnt <= '0;
                        if (bitCnt == BitLast) begin
                            state  <= StStop;
                            otxReg <= 1'b1;
                        end else begin
                            bitCnt   <= bitCnt + BitW'(1);
                            otxReg   <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                        end
                    end else begin
                        baudCnt <= baudCnt + BaudW'(1);
                    end
                end

                StStop: begin
                    if (baudCnt == BaudLast) begin
                        baudCnt <= '0;
                        state   <= StIdle;
                        busyReg <= 1'b0;
                        doneReg <= 1'b0;
                    end else begin
                        baudCnt <= baudCnt + BaudW'(1);
                        // Registered pulse: raise one edge early so it lands on the last cycle.
                        if (baudCnt == BaudPenult) begin
                            doneReg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= StIdle;
                    otxReg  <= 1'b1;
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx -- directed bench for fifo_serial_tx.
// dut uses CLKS_PER_BIT=4 (72-cycle frames) fed by a small bench FIFO; dut2 uses
// CLKS_PER_BIT=2 for the width/position check.
module tb_fifo_serial_tx;

    logic iclk = 1'b0;
    logic ireset;

    always #5 iclk = ~iclk;

    fifo_serial_tx_if #(.DATA_W(16)) bus ();
    fifo_serial_tx_if #(.DATA_W(16)) bus2 ();

    fifo_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(16)) dut (
        .iclk   (iclk),
        .ireset (ireset),
        .bus    (bus)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(2), .DATA_W(16)) dut2 (
        .iclk   (iclk),
        .ireset (ireset),
        .bus    (bus2)
    );

    // Bench show-ahead FIFO feeding dut.
    logic [15:0] mem [8];
    logic [3:0]  wrPtr = 4'd0;
    logic [3:0]  rdPtr = 4'd0;
    logic        flush = 1'b0;

    assign bus.iempty  = (rdPtr == wrPtr);
    assign bus.ir_data = mem[rdPtr[2:0]];

    always @(posedge iclk) begin
        if (flush) rdPtr <= wrPtr;
        else if (bus.ord) rdPtr <= rdPtr + 4'd1;
    end

    int cyc       = 0;
    int ordCount  = 0;
    int doneCount = 0;

    always @(posedge iclk) begin
        cyc <= cyc + 1;
        if (bus.ord) ordCount <= ordCount + 1;
        if (bus.odone) doneCount <= doneCount + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wrPtr[2:0]] = w;
        wrPtr = wrPtr + 4'd1;
    endtask

    // Call in the ord cycle (after its negedge). Checks the 72 frame cycles plus the idle
    // cycle after them; returns at the negedge of that idle cycle. dropAt>0 lowers ienable
    // after sampling frame cycle dropAt.
    task automatic checkFrame(input string tag, input logic [15:0] word, input int dropAt);
        int   otxErr  = 0;
        int   busyErr = 0;
        int   doneErr = 0;
        int   ordHits = 0;
        logic expOtx;
        for (int c = 1; c <= 73; c++) begin
            @(negedge iclk);
            if (c <= 4) expOtx = 1'b0;
            else if (c <= 68) expOtx = word[(c - 5) / 4];
            else expOtx = 1'b1;
            if (bus.otx !== expOtx) otxErr++;
            if (bus.obusy !== (c <= 72)) busyErr++;
            if (bus.odone !== (c == 72)) doneErr++;
            if (c <= 72 && bus.ord === 1'b1) ordHits++;
            if (c == dropAt) bus.ienable = 1'b0;
        end
        checkEq({tag, "_otx_bad_cycles"}, otxErr, 0);
        checkEq({tag, "_busy_bad_cycles"}, busyErr, 0);
        checkEq({tag, "_done_bad_cycles"}, doneErr, 0);
        checkEq({tag, "_ord_in_frame"}, ordHits, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ordCyc1;
        int base;
        int idleErr;

        ireset       = 1'b1;
        bus.ienable  = 1'b1;
        bus2.ienable = 1'b1;
        bus2.iempty  = 1'b1;
        bus2.ir_data = 16'h0000;
        push(16'hA5C3);

        // Reset state: FIFO non-empty and enabled, yet no pop while in reset.
        repeat (3) @(negedge iclk);
        checkEq("rst_otx", bus.otx, 1);
        checkEq("rst_busy", bus.obusy, 0);
        checkEq("rst_done", bus.odone, 0);
        checkEq("rst_ord", bus.ord, 0);

        // Single word: pop on the first eligible cycle after release.
        ireset = 1'b0;
        #1;
        checkEq("single_first_pop", bus.ord, 1);
        checkFrame("single", 16'hA5C3, 0);
        checkEq("single_idle_ord", bus.ord, 0);

        // Back-to-back frames.
        push(16'h0001);
        push(16'hFFFF);
        #1;
        checkEq("b2b_ord1", bus.ord, 1);
        ordCyc1 = cyc;
        checkFrame("b2b_first", 16'h0001, 0);
        checkEq("b2b_ord2", bus.ord, 1);
        checkEq("b2b_spacing", cyc - ordCyc1, 73);
        checkFrame("b2b_second", 16'hFFFF, 0);

        // Empty FIFO with enable high: nothing happens, then pop the same cycle data shows up.
        idleErr = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge iclk);
            if (bus.ord !== 1'b0 || bus.otx !== 1'b1 || bus.obusy !== 1'b0) idleErr++;
        end
        checkEq("empty_idle_bad_cycles", idleErr, 0);
        push(16'h1234);
        #1;
        checkEq("empty_then_pop", bus.ord, 1);
        checkFrame("after_empty", 16'h1234, 0);

        // Enable drop during DATA bit 5 (frame cycles 25..28) with 3 words queued.
        base = doneCount;
        push(16'h00FF);
        push(16'h1111);
        push(16'h2222);
        #1;
        checkEq("drop_pop", bus.ord, 1);
        checkFrame("drop", 16'h00FF, 26);
        idleErr = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge iclk);
            if (bus.ord !== 1'b0 || bus.obusy !== 1'b0) idleErr++;
        end
        checkEq("drop_no_pop", idleErr, 0);
        checkEq("drop_done_once", doneCount - base, 1);
        flush = 1'b1;
        @(negedge iclk);
        flush = 1'b0;
        bus.ienable = 1'b1;

        // Reset during DATA bit 8 (frame cycles 37..40).
        push(16'hBEEF);
        #1;
        checkEq("rstmid_pop", bus.ord, 1);
        repeat (38) @(negedge iclk);
        checkEq("rstmid_busy_before", bus.obusy, 1);
        checkEq("rstmid_bit8", bus.otx, 0);
        ireset = 1'b1;
        #1;
        checkEq("rstmid_otx", bus.otx, 1);
        checkEq("rstmid_busy", bus.obusy, 0);
        checkEq("rstmid_done", bus.odone, 0);
        repeat (3) @(negedge iclk);
        ireset = 1'b0;
        base = ordCount;
        repeat (5) @(negedge iclk);
        checkEq("rstmid_no_repop", ordCount - base, 0);
        push(16'h5A5A);
        #1;
        checkEq("rstmid_new_pop", bus.ord, 1);
        checkFrame("after_rst", 16'h5A5A, 0);
        repeat (5) @(negedge iclk);
        checkEq("rstmid_one_pop", ordCount - base, 1);

        // CLKS_PER_BIT=2 with 16'h8000: bit15 in cycles 33-34, stop in 35-36.
        bus2.ir_data = 16'h8000;
        bus2.iempty  = 1'b0;
        #1;
        checkEq("w2_pop", bus2.ord, 1);
        for (int c = 1; c <= 37; c++) begin
            @(negedge iclk);
            if (c == 1) bus2.iempty = 1'b1;
            if (c == 2) checkEq("w2_start", bus2.otx, 0);
            if (c == 32) checkEq("w2_bit14", bus2.otx, 0);
            if (c == 33) checkEq("w2_msb_a", bus2.otx, 1);
            if (c == 34) checkEq("w2_msb_b", bus2.otx, 1);
            if (c == 35) checkEq("w2_stop_a", bus2.otx, 1);
            if (c == 35) checkEq("w2_done_early", bus2.odone, 0);
            if (c == 36) checkEq("w2_done", bus2.odone, 1);
            if (c == 37) checkEq("w2_idle", bus2.obusy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..1024.
REQ-002 Parameter DATA_W, default 16, word width popped from the FIFO and serialised.
REQ-003 iclk  input  1  sole clock; all state updates on rising edge.
REQ-004 ireset  input  1  reset, asynchronous, active-high.
REQ-005 ienable  input  1  permits starting a new frame; sampled only in IDLE.
REQ-006 iempty  input  1  FIFO empty flag.
REQ-007 ir_data  input  DATA_W  FIFO show-ahead read data, valid whenever iempty is low.
REQ-008 ord  output  1  FIFO pop strobe, one cycle per word.
REQ-009 otx  output  1  serial line, idle high.
REQ-010 obusy  output  1  high whenever state is not IDLE.
REQ-011 odone  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-013 ord SHALL be combinational: state==IDLE & ienable & ~iempty & ~ireset.
REQ-014 In the cycle ord is high, the block SHALL capture ir_data into the shift register and move to START on that edge.
REQ-015 ord SHALL never assert outside IDLE, so exactly one pop occurs per frame.
REQ-016 iempty and ienable SHALL be ignored outside IDLE.
REQ-017 START: otx low for exactly CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: DATA_W bits LSB first, each held for exactly CLKS_PER_BIT cycles, then STOP.
REQ-019 STOP: otx high for CLKS_PER_BIT cycles, then IDLE.
REQ-020 odone SHALL be high in the last STOP cycle only.
REQ-021 otx SHALL be registered; the first start-bit cycle is the cycle after the ord cycle.
REQ-022 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles.
REQ-023 Back-to-back timing: the minimum frame-to-frame spacing SHALL be (DATA_W+2)*CLKS_PER_BIT+1 cycles, i.e. one IDLE cycle with otx high between frames.
REQ-024 Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; width is clog2(CLKS_PER_BIT).
REQ-025 Bit counter: counts 0..DATA_W-1 and is cleared on entry to DATA.
REQ-026 If ienable falls mid-frame, the current frame SHALL complete unchanged; no further pop occurs.
REQ-027 iempty rising mid-frame SHALL have no effect on the current frame.
REQ-028 In IDLE with iempty high or ienable low, otx SHALL stay 1 and ord 0 indefinitely.

Reset
REQ-029 While ireset is high, the block SHALL immediately force: state IDLE, otx=1, ord=0, obusy=0, odone=0, counters=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame.
REQ-031 An aborted word SHALL be lost and SHALL NOT be re-popped after reset.
REQ-032 After release, the first pop SHALL occur on the first cycle that meets REQ-013.

Verification (CLKS_PER_BIT=4, DATA_W=16)
REQ-033 Single word: FIFO holds 16'hA5C3, ienable=1.
 -> ord is 1 cycle.
 -> otx = 0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
 -> odone pulses at cycle 72 after ord; obusy high for 72 cycles.
REQ-034 Back-to-back: FIFO holds 16'h0001 and 16'hFFFF.
 -> two ord pulses exactly 73 cycles apart.
 -> the second frame's start bit follows exactly one idle-high cycle.
REQ-035 Empty FIFO: iempty=1, ienable=1 for 200 cycles.
 -> ord=0, otx=1, obusy=0 throughout.
 -> then iempty falls: ord pulses the same cycle.
REQ-036 Enable drop: ienable falls during DATA bit 5 with 3 words queued.
 -> the current frame completes, odone pulses once.
 -> no further ord while ienable is low.
REQ-037 Reset mid-frame: ireset asserted during DATA bit 8.
 -> otx=1 and obusy=0 in the same cycle.
 -> after release with 1 word queued, exactly one ord and one full 72-cycle frame.
REQ-038 Width check: with CLKS_PER_BIT=2 and 16'h8000, the MSB data bit is high in cycles 33-34 after ord and the stop bit in cycles 35-36.
